// File: rtl/capture_fifo_sink.sv
// capture_fifo_sink: after a start pulse, waits out the upstream pipeline latency, captures
// capture_len consecutive words into a FIFO, and drains that FIFO through a valid/ready port.
module capture_fifo_sink #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   capture_len,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int WW    = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  push, pop, push_ok;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rem_d   = rem_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && capture_len != '0) begin
          state_d = (PIPE_LATENCY > 1) ? S_WAIT : S_ACTIVE;
          wait_d  = WW'(PIPE_LATENCY - 1);
          rem_d   = capture_len;
        end
      end
      S_WAIT: begin
        wait_d  = wait_q - 1'b1;
        state_d = (wait_q <= WW'(1)) ? S_ACTIVE : S_WAIT;
      end
      S_ACTIVE: begin
        push    = 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == (ADDR_WIDTH+1)'(1)) ? S_DONE : S_ACTIVE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO still takes the word when the head leaves on the same edge.
  always_comb begin
    pop      = (count_q != '0) && out_ready;
    push_ok  = push && (!count_q[ADDR_WIDTH] || pop);
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push_ok);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop);
    count_d  = count_q + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop);
    ovf_d    = (state_q == S_IDLE && start && capture_len != '0) ? 1'b0 :
               (push && !push_ok) ? 1'b1 : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= data_in;
  end

  assign out_valid = count_q != '0;
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign count     = count_q;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_capture_fifo_sink.sv
// tb_capture_fifo_sink: directed and random steps checked against a queue-based capture-window model.
module tb_capture_fifo_sink;
  localparam int DW = 32, AW = 4, L = 4, DEPTH = 16;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [AW:0]   capture_len = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          out_valid, busy, done, overflow;
  int            checks = 0, failures = 0, n = 0;
  logic [DW-1:0] q[$];
  bit            ovf_m = 1'b0;
  int            s_m = -100, end_m = -100;
  string         phase = "reset";

  capture_fifo_sink #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .capture_len(capture_len), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture edges of a start accepted at edge s are s+L .. s+L+len-1; busy until edge s+L+len.
  task automatic model();
    bit pop, cap, full;
    pop  = (q.size() != 0) && out_ready;
    cap  = (n >= s_m + L) && (n <= end_m - 1);
    full = q.size() >= DEPTH;
    if (pop) void'(q.pop_front());
    if (cap) begin
      if (!full || pop) q.push_back(data_in);
      else ovf_m = 1'b1;
    end
    if (n > end_m && start && capture_len != '0) begin
      s_m   = n;
      end_m = n + L + int'(capture_len);
      ovf_m = 1'b0;
    end
  endtask

  task automatic check_all();
    chk({phase, ":count"}, DW'(count), DW'(q.size()));
    chk({phase, ":out_valid"}, DW'(out_valid), DW'(q.size() != 0));
    chk({phase, ":out_data"}, out_data, (q.size() != 0) ? q[0] : '0);
    chk({phase, ":busy"}, DW'(busy), DW'(n >= s_m && n < end_m));
    chk({phase, ":done"}, DW'(done), DW'(n == end_m - 1));
    chk({phase, ":overflow"}, DW'(overflow), DW'(ovf_m));
  endtask

  task automatic step(bit st, int ln, bit rdy);
    start       = st;
    capture_len = (AW+1)'(ln);
    out_ready   = rdy;
    data_in     = $urandom;
    @(posedge clk);
    if (rst_n) model();
    @(negedge clk);
    check_all();
    n++;
  endtask

  initial begin
    repeat (3) step(0, 0, 0);
    rst_n = 1'b1;
    phase = "basic";
    step(1, 3, 0);
    repeat (8) step(0, 0, 0);
    chk("basic_count", DW'(count), 3);
    phase = "drain";
    repeat (5) step(0, 0, 1);
    chk("drain_empty", DW'(out_valid), 0);
    phase = "ovf";
    step(1, 18, 0);
    repeat (24) step(0, 0, 0);
    chk("ovf_flag", DW'(overflow), 1);
    chk("ovf_count", DW'(count), 16);
    phase = "fullpop";
    step(1, 4, 0);
    repeat (3) step(0, 0, 0);
    repeat (4) step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    chk("fullpop_ovf", DW'(overflow), 0);
    chk("fullpop_count", DW'(count), 16);
    repeat (20) step(0, 0, 1);
    phase = "ignore";
    step(1, 5, 0);
    repeat (5) step(0, 0, 0);
    step(1, 9, 0);
    repeat (6) step(0, 0, 0);
    chk("ignore_len", DW'(count), 5);
    step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    chk("ignore_zero_busy", DW'(busy), 0);
    repeat (8) step(0, 0, 1);
    phase = "random";
    repeat (400) step($urandom_range(0, 7) == 0, $urandom_range(0, 20), 1'($urandom_range(0, 1)));
    phase = "midreset";
    repeat (40) step(0, 0, 1);
    step(1, 6, 0);
    repeat (5) step(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", DW'(busy), 0);
    chk("rst_count", DW'(count), 0);
    chk("rst_valid", DW'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", DW'(overflow), 0);
    q.delete();
    ovf_m = 1'b0;
    s_m   = -100;
    end_m = -100;
    repeat (2) step(0, 0, 0);
    rst_n = 1'b1;
    phase = "post";
    step(1, 3, 0);
    repeat (8) step(0, 0, 0);
    chk("post_count", DW'(count), 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
